// File: rtl/vga_timing_detect.sv
// Recovers pixel/line position and measures line/frame timing from a VGA sync/blank stream.
// Optional macro VGA_TIMING_DETECT_SYNCW_EN builds the hsync/vsync pulse width counters.
module vga_timing_detect #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] hsync_width,
  output logic [10:0] vsync_width,
  output logic        locked,
  output logic        err
);

  localparam logic [10:0] CNT_MAX = 11'd2047;
  localparam logic [3:0]  LOCK_M  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] val);
    return (val == CNT_MAX) ? CNT_MAX : val + 11'd1;
  endfunction

  // {vblnk, hblnk, vsync, hsync}
  logic [3:0]  in_r;
  logic [3:0]  prev_r;
  logic        in_vld_r;
  logic        prev_vld_r;
  logic        hs_rise_s;
  logic        vs_rise_s;
  logic        hb_fall_s;
  logic        vb_fall_s;

  logic        vb_pend_r;
  logic [10:0] line_cnt_r;
  logic        line_vld_r;
  logic [10:0] frm_cnt_r;
  logic [10:0] first_len_r;
  logic        first_vld_r;
  logic        incons_r;

  logic        line_sat_s;
  logic        line_bad_s;
  logic [10:0] frm_len_s;
  logic        frm_sat_s;
  logic [10:0] first_len_s;
  logic        first_vld_s;
  logic        incons_s;
  logic        frame_ok_s;
  logic        lock_err_s;

  state_t      state_r;
  logic [10:0] ref_h_r;
  logic [10:0] ref_v_r;
  logic        ref_vld_r;
  logic [3:0]  match_r;
  logic [3:0]  match_nxt_s;

  // Register the inputs once; history is only trusted after two real samples
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r       <= 4'b0000;
      prev_r     <= 4'b0000;
      in_vld_r   <= 1'b0;
      prev_vld_r <= 1'b0;
    end else begin
      in_r       <= {vblnk_in, hblnk_in, vsync_in, hsync_in};
      prev_r     <= in_r;
      in_vld_r   <= 1'b1;
      prev_vld_r <= in_vld_r;
    end
  end

  assign hs_rise_s = prev_vld_r &  in_r[0] & ~prev_r[0];
  assign vs_rise_s = prev_vld_r &  in_r[1] & ~prev_r[1];
  assign hb_fall_s = prev_vld_r & ~in_r[2] &  prev_r[2];
  assign vb_fall_s = prev_vld_r & ~in_r[3] &  prev_r[3];

  // Pixel and line position recovery, running regardless of lock
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount    <= 11'd0;
      vcount    <= 11'd0;
      vb_pend_r <= 1'b0;
    end else begin
      if (hb_fall_s) begin
        hcount    <= 11'd0;
        // a vblnk fall coincident with the hblnk fall belongs to this line
        if (vb_fall_s || vb_pend_r) begin
          vcount <= 11'd0;
        end else begin
          vcount <= sat_inc(vcount);
        end
        vb_pend_r <= 1'b0;
      end else begin
        hcount    <= sat_inc(hcount);
        vcount    <= vcount;
        vb_pend_r <= vb_pend_r | vb_fall_s;
      end
    end
  end

  // Frame-close view: a line ending on the vsync edge is counted first
  always_comb begin
    line_sat_s  = (line_cnt_r == CNT_MAX);
    line_bad_s  = hs_rise_s & (line_sat_s | ~line_vld_r);
    if (hs_rise_s) begin
      frm_len_s = sat_inc(frm_cnt_r);
    end else begin
      frm_len_s = frm_cnt_r;
    end
    frm_sat_s   = (frm_len_s == CNT_MAX);
    if (first_vld_r) begin
      first_len_s = first_len_r;
    end else begin
      first_len_s = line_cnt_r;
    end
    first_vld_s = first_vld_r | hs_rise_s;
    incons_s    = incons_r | line_bad_s |
                  (hs_rise_s & first_vld_r & (line_cnt_r != first_len_r));
    frame_ok_s  = first_vld_s & ~incons_s & ~frm_sat_s;
    lock_err_s  = line_sat_s | frm_sat_s |
                  (hs_rise_s & (line_cnt_r != h_total)) |
                  (vs_rise_s & (frm_len_s != v_total));
    match_nxt_s = match_r + 4'd1;
  end

  // Line length (clocks between hsync rises) and per-frame consistency tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt_r  <= 11'd0;
      line_vld_r  <= 1'b0;
      frm_cnt_r   <= 11'd0;
      first_len_r <= 11'd0;
      first_vld_r <= 1'b0;
      incons_r    <= 1'b0;
    end else begin
      if (hs_rise_s) begin
        line_cnt_r <= 11'd1;
        line_vld_r <= 1'b1;
      end else begin
        line_cnt_r <= sat_inc(line_cnt_r);
        line_vld_r <= line_vld_r;
      end
      if (vs_rise_s) begin
        frm_cnt_r   <= 11'd0;
        first_len_r <= 11'd0;
        first_vld_r <= 1'b0;
        incons_r    <= 1'b0;
      end else begin
        frm_cnt_r   <= frm_len_s;
        first_len_r <= first_len_s;
        first_vld_r <= first_vld_s;
        incons_r    <= incons_s;
      end
    end
  end

  // Lock FSM: compare closed frames against a reference, then police the locked timing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= SEARCH;
      ref_h_r   <= 11'd0;
      ref_v_r   <= 11'd0;
      ref_vld_r <= 1'b0;
      match_r   <= 4'd0;
      h_total   <= 11'd0;
      v_total   <= 11'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_r)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_rise_s) begin
            state_r   <= MEASURE;
            ref_vld_r <= 1'b0;
            match_r   <= 4'd0;
          end else begin
            state_r <= SEARCH;
          end
        end
        MEASURE: begin
          if (vs_rise_s) begin
            if (frame_ok_s && ref_vld_r &&
                (first_len_s == ref_h_r) && (frm_len_s == ref_v_r)) begin
              if (match_nxt_s == LOCK_M) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
                h_total <= ref_h_r;
                v_total <= ref_v_r;
                match_r <= 4'd0;
              end else begin
                match_r <= match_nxt_s;
              end
            end else begin
              // an inconsistent frame cannot serve as a reference
              ref_vld_r <= frame_ok_s;
              ref_h_r   <= first_len_s;
              ref_v_r   <= frm_len_s;
              match_r   <= 4'd0;
            end
          end else begin
            state_r <= MEASURE;
          end
        end
        LOCKED: begin
          if (lock_err_s) begin
            err     <= 1'b1;
            locked  <= 1'b0;
            state_r <= SEARCH;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_TIMING_DETECT_SYNCW_EN
  logic        hs_fall_s;
  logic        vs_fall_s;
  logic [10:0] hsw_cnt_r;
  logic [10:0] vsw_cnt_r;

  assign hs_fall_s = prev_vld_r & ~in_r[0] & prev_r[0];
  assign vs_fall_s = prev_vld_r & ~in_r[1] & prev_r[1];

  // Sync pulse widths: hsync in clocks, vsync in hsync rises (lines)
  always_ff @(posedge clk) begin
    if (rst) begin
      hsw_cnt_r   <= 11'd0;
      vsw_cnt_r   <= 11'd0;
      hsync_width <= 11'd0;
      vsync_width <= 11'd0;
    end else begin
      if (hs_rise_s) begin
        hsw_cnt_r <= 11'd1;
      end else if (in_r[0]) begin
        hsw_cnt_r <= sat_inc(hsw_cnt_r);
      end else begin
        hsw_cnt_r <= hsw_cnt_r;
      end
      if (vs_rise_s) begin
        vsw_cnt_r <= {10'd0, hs_rise_s};
      end else if (in_r[1] && hs_rise_s) begin
        vsw_cnt_r <= sat_inc(vsw_cnt_r);
      end else begin
        vsw_cnt_r <= vsw_cnt_r;
      end
      if (hs_fall_s) begin
        hsync_width <= hsw_cnt_r;
      end else begin
        hsync_width <= hsync_width;
      end
      if (vs_fall_s) begin
        vsync_width <= vsw_cnt_r;
      end else begin
        vsync_width <= vsync_width;
      end
    end
  end
`else
  assign hsync_width = 11'd0;
  assign vsync_width = 11'd0;
`endif

endmodule

// File: tb/tb_vga_timing_detect.sv
// Bench for vga_timing_detect: a scaled 800x600-shaped stream (48x16 total, 32x10 active,
// hsync 8 clocks, vsync 4 lines) with expectations queued at drive time and retired at output time.
module tb_vga_timing_detect;

  localparam int H_ACT = 32;
  localparam int H_TOT = 48;
  localparam int HS_B  = 36;
  localparam int HS_E  = 43;
  localparam int V_ACT = 10;
  localparam int V_TOT = 16;
  localparam int VS_B  = 11;
  localparam int VS_E  = 14;
`ifdef VGA_TIMING_DETECT_SYNCW_EN
  localparam logic [10:0] EXP_HSW = 11'd8;
  localparam logic [10:0] EXP_VSW = 11'd4;
`else
  localparam logic [10:0] EXP_HSW = 11'd0;
  localparam logic [10:0] EXP_VSW = 11'd0;
`endif

  localparam int K_HC = 0, K_VC = 1, K_HT = 2, K_VT = 3;
  localparam int K_HW = 4, K_VW = 5, K_LK = 6, K_ER = 7, NK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [10:0] hcount, vcount, h_total, v_total, hsync_width, vsync_width;
  logic        locked, err;

  vga_timing_detect #(.LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount(hcount), .vcount(vcount), .h_total(h_total), .v_total(v_total),
    .hsync_width(hsync_width), .vsync_width(vsync_width),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   vs_cnt = 0;
  int   rst_cyc = 0;
  bit   lock_exp = 1'b0;
  bit   pix_ok = 1'b0;

  function automatic string kind_name(input int kind);
    case (kind)
      K_HC: return "hcount";
      K_VC: return "vcount";
      K_HT: return "h_total";
      K_VT: return "v_total";
      K_HW: return "hsync_width";
      K_VW: return "vsync_width";
      K_LK: return "locked";
      K_ER: return "err";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [10:0] observe(input int kind);
    case (kind)
      K_HC: return hcount;
      K_VC: return vcount;
      K_HT: return h_total;
      K_VT: return v_total;
      K_HW: return hsync_width;
      K_VW: return vsync_width;
      K_LK: return {10'd0, locked};
      K_ER: return {10'd0, err};
      default: return 11'bx;
    endcase
  endfunction

  task automatic expect_at(input int due, input int kind, input logic [10:0] val);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and retire every expectation due now
  task automatic tick();
    exp_t        e;
    logic [10:0] obs;
    @(negedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (e.due == cyc && obs === e.val) else begin
        errors++;
        $error("FAIL %s cycle=%0d observed=%0d expected=%0d", kind_name(e.kind), cyc, obs, e.val);
      end
    end
  endtask

  // One clock of stimulus; outputs caused by it are expected two clocks later
  task automatic step(input logic hs, input logic vs, input logic hb, input logic vb,
                      input int h, input int v, input bit act, input bit err_here,
                      input bit rst_here);
    tick();
    if (rst_here) begin
      sb.delete();
      for (int k = 0; k < NK; k++) expect_at(cyc + 1, k, 11'd0);
      lock_exp = 1'b0;
      vs_cnt   = 0;
      pix_ok   = 1'b0;
      rst_cyc  = cyc;
    end else begin
      if (vs && !vsync_in) begin
        vs_cnt++;
        if (!lock_exp && vs_cnt == 4) begin
          lock_exp = 1'b1;
          expect_at(cyc + 2, K_HT, 11'(H_TOT));
          expect_at(cyc + 2, K_VT, 11'(V_TOT));
          expect_at(cyc + 2, K_HW, EXP_HSW);
          expect_at(cyc + 2, K_VW, EXP_VSW);
        end
      end
      if (err_here) begin
        lock_exp = 1'b0;
        vs_cnt   = 0;
      end
      if (act && pix_ok) begin
        expect_at(cyc + 2, K_HC, 11'(h));
        expect_at(cyc + 2, K_VC, 11'(v));
      end
    end
    expect_at(cyc + 2, K_ER, {10'd0, err_here});
    expect_at(cyc + 2, K_LK, {10'd0, lock_exp});
    rst      = rst_here;
    hsync_in = hs;
    vsync_in = vs;
    hblnk_in = hb;
    vblnk_in = vb;
  endtask

  task automatic px(input int h, input int v, input bit err_here, input bit rst_here);
    if (h == 0 && v == 0 && !rst_here) pix_ok = (cyc - rst_cyc) > 4;
    step(h >= HS_B && h <= HS_E, v >= VS_B && v <= VS_E, h >= H_ACT, v >= V_ACT,
         h, v, (h < H_ACT) && (v < V_ACT), err_here, rst_here);
  endtask

  // One frame; optionally stretch one line by a clock, or pulse reset mid-line
  task automatic frame(input int stretch_line, input int rst_line);
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        px(h, v, (v == stretch_line) && (h == HS_B), (v == rst_line) && (h == 20));
        if (v == stretch_line && h == 34) px(h, v, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // lock after the 4th vsync rise, then stay locked
    for (int f = 0; f < 6; f++) frame(-1, -1);
    // one 49-clock line while locked, then relock
    frame(3, -1);
    for (int f = 0; f < 4; f++) frame(-1, -1);
    // reset pulse mid-frame while locked, then relock
    frame(-1, 5);
    for (int f = 0; f < 5; f++) frame(-1, -1);

    // reach MEASURE with a partial match, then 3000 short lines without vsync
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) frame(-1, -1);
    for (int v = 0; v < VS_B; v++)
      for (int h = 0; h < H_TOT; h++) px(h, v, 1'b0, 1'b0);
    px(0, VS_B, 1'b0, 1'b0);
    for (int l = 0; l < 3000; l++)
      for (int h = 0; h < 8; h++)
        step(h >= 5 && h <= 6, 1'b0, h >= 4, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    vs_cnt = 0;
    for (int f = 0; f < 5; f++) frame(-1, -1);

    tick();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_detect.md
VGA_TIMING_DETECT -- requirements
Module: vga_timing_detect

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, is the number of consecutive matching frames required to assert lock (legal range 1..15).
REQ-002 clk  input  1  pixel clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hsync_in  input  1  horizontal sync, active-high, from a vga_timing-style source.
REQ-005 vsync_in  input  1  vertical sync, active-high.
REQ-006 hblnk_in  input  1  horizontal blank, active-high.
REQ-007 vblnk_in  input  1  vertical blank, active-high.
REQ-008 hcount  output  11  recovered pixel index; 0 on the first active pixel of a line.
REQ-009 vcount  output  11  recovered line index; 0 on the first active line of a frame.
REQ-010 h_total  output  11  measured clocks per line; meaningful while locked.
REQ-011 v_total  output  11  measured lines per frame; meaningful while locked.
REQ-012 hsync_width  output  11  measured hsync high width in clocks.
REQ-013 vsync_width  output  11  measured vsync high width in lines.
REQ-014 locked  output  1  timing stable; high for as long as lock holds.
REQ-015 err  output  1  one-cycle pulse on loss of lock.

Function
REQ-016 The block SHALL register all four inputs once and detect edges as registered value differing from its previous registered value; all outputs are registered.
REQ-017 hcount SHALL load 0 in the cycle after a hblnk_in falling edge is sampled, otherwise increment by 1, saturating at 2047.
REQ-018 vcount SHALL increment on each hblnk_in falling edge, and load 0 on the first hblnk_in falling edge after a vblnk_in falling edge, saturating at 2047.
REQ-019 Line length SHALL be the clock count between consecutive hsync_in rising edges; frame length SHALL be the count of hsync_in rising edges between consecutive vsync_in rising edges; both counters saturate at 2047.
REQ-020 FSM states SHALL be SEARCH, MEASURE and LOCKED.
REQ-021 SEARCH -> MEASURE SHALL occur on the first vsync_in rising edge; the frame counters clear there.
REQ-022 In MEASURE, each vsync_in rising edge SHALL close a frame; a frame is consistent if every line length equals the frame's first line length and no counter saturated.
REQ-023 The first consistent frame SHALL become the reference (match count 0); each subsequent consistent frame equal to the reference in line and frame length SHALL increment match count; an unequal or inconsistent frame SHALL become the new reference with match count 0.
REQ-024 When match count reaches LOCK_FRAMES, the FSM SHALL enter LOCKED, latch h_total and v_total, and assert locked in the following cycle.
REQ-025 In LOCKED, any line length differing from h_total, any frame length differing from v_total, or any counter saturation SHALL pulse err for exactly one cycle, deassert locked in the same cycle, and return the FSM to SEARCH.
REQ-026 Simultaneous hsync_in and vsync_in rising edges SHALL count the line before closing the frame.
REQ-027 hcount and vcount SHALL run in every state, independent of lock.

Reset
REQ-028 When rst is high at a clock edge, the FSM SHALL enter SEARCH, all counters and outputs SHALL be 0, and locked and err SHALL be 0 on the next cycle, including when rst is asserted mid-frame while LOCKED.
REQ-029 Input edge history SHALL clear on reset, so an input held high through reset release does not produce an edge.

Configuration
REQ-030 With macro VGA_TIMING_DETECT_SYNCW_EN defined, hsync_width SHALL update at each hsync_in falling edge and vsync_width at each vsync_in falling edge, both saturating at 2047.
REQ-031 Without VGA_TIMING_DETECT_SYNCW_EN, hsync_width and vsync_width SHALL be constant 0 and the width counters SHALL not be built; all other behaviour is unchanged.

Verification
REQ-032 Drive the vga_timing 800x600 stream (1056x628, hsync at 840..967, vsync lines 601..604) with LOCK_FRAMES=2 -> locked rises one cycle after the 4th vsync rising edge, h_total=1056 and v_total=628.
REQ-033 Same stream -> hcount=0 on the pixel after hblnk falls and hcount=799 at the last active pixel; vcount=0..599 over the active lines.
REQ-034 Same stream with SYNCW_EN defined -> hsync_width=128 and vsync_width=4; without SYNCW_EN -> both 0.
REQ-035 While locked, stretch one line to 1057 clocks -> err is high for 1 cycle, locked falls in the same cycle, and lock is reacquired after 4 further vsync rising edges.
REQ-036 Assert rst for 1 cycle mid-frame while locked -> all outputs 0 next cycle, no err pulse, and relock occurs per REQ-032.
REQ-037 Hold vsync_in low for 3000 lines -> frame counter saturates at 2047, locked never asserts, and err never pulses outside LOCKED.
